// File: rtl/neck_pkg.sv
// Shared state encoding, clock-derived timing defaults and counter sizing
// for the necking pulse controller.
package neck_pkg;

  localparam int unsigned CLK_FREQ_HZ      = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = 4;
  localparam int unsigned DEF_PULSE_CYC    = CLK_FREQ_HZ / 200_000;  // 5 us
  localparam int unsigned DEF_HOLDOFF_CYC  = CLK_FREQ_HZ / 5_000;    // 200 us
  localparam int unsigned DEF_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_PULSE   = 2'd2,
    ST_HOLDOFF = 2'd3
  } neck_state_e;

  // Width able to hold 0..n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/neck_debounce.sv
// Debounce and re-arm tracking: counts consecutive high samples of the raw
// necking flag and raises a one-cycle qualified strobe for the main FSM.
module neck_debounce
  import neck_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_ctrl,
  input  logic        necking_in,
  input  neck_state_e state_i,
  output logic        qual_o,
  output logic        qualifying_o,
  output logic        armed_o
);

  localparam int unsigned   QW        = cnt_width(DEBOUNCE_CYC);
  localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE_CYC);

  logic [QW-1:0] qual_cnt_q, qual_cnt_d, qual_cnt_inc;
  logic          armed_q, armed_d;
  logic          in_window;

  always_comb begin
    in_window    = (state_i == ST_IDLE) || (state_i == ST_QUALIFY);
    qual_cnt_inc = qual_cnt_q + QW'(1);
    qual_o       = 1'b0;
    qual_cnt_d   = '0;
    armed_d      = armed_q;

    if (in_window && !necking_in) armed_d = 1'b1;

    case (state_i)
      ST_IDLE: begin
        if (en_ctrl && armed_q && necking_in) begin
          if (DEBOUNCE_CYC == 1) qual_o     = 1'b1;
          else                   qual_cnt_d = QW'(1);
        end
      end
      ST_QUALIFY: begin
        if (en_ctrl && necking_in) begin
          if (qual_cnt_inc == QUAL_LAST) qual_o     = 1'b1;
          else                           qual_cnt_d = qual_cnt_inc;
        end
      end
      default: ;
    endcase

    // Firing consumes the arm; a fresh low sample is needed for the next event.
    if (qual_o) armed_d = 1'b0;
    qualifying_o = (qual_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qual_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      qual_cnt_q <= qual_cnt_d;
      armed_q    <= armed_d;
    end
  end

  assign armed_o = armed_q;

endmodule

// File: rtl/neck_pulse_ctrl.sv
// Necking pulse controller: debounced trigger, fixed-width registered pulse,
// hold-off window and saturating event counter.
module neck_pulse_ctrl
  import neck_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned PULSE_CYC    = DEF_PULSE_CYC,
  parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_ctrl,
  input  logic             necking_in,
  input  logic             abort_in,
  output logic             neck_pulse,
  output logic             busy,
  output logic             armed,
  output logic [CNT_W-1:0] event_cnt,
  output logic [1:0]       ctrl_state
);

  localparam int unsigned   PW         = cnt_width(PULSE_CYC);
  localparam int unsigned   HW         = cnt_width(HOLDOFF_CYC);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'((HOLDOFF_CYC == 0) ? 0 : HOLDOFF_CYC - 1);

  neck_state_e      state_q, state_d, after_pulse;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic             neck_pulse_q;
  logic             qual, qualifying;

  neck_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .en_ctrl      (en_ctrl),
    .necking_in   (necking_in),
    .state_i      (state_q),
    .qual_o       (qual),
    .qualifying_o (qualifying),
    .armed_o      (armed)
  );

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = '0;
    hold_cnt_d  = '0;
    event_cnt_d = event_cnt_q;
    after_pulse = ST_HOLDOFF;
    if (HOLDOFF_CYC == 0) after_pulse = ST_IDLE;

    case (state_q)
      ST_IDLE, ST_QUALIFY: begin
        if (qual)            state_d = ST_PULSE;
        else if (qualifying) state_d = ST_QUALIFY;
        else                 state_d = ST_IDLE;
      end
      ST_PULSE: begin
        if (abort_in || (pulse_cnt_q == PULSE_LAST)) state_d = after_pulse;
        else pulse_cnt_d = pulse_cnt_q + PW'(1);
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
        else hold_cnt_d = hold_cnt_q + HW'(1);
      end
    endcase

    if (qual && (event_cnt_q != '1)) event_cnt_d = event_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pulse_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      event_cnt_q  <= '0;
      neck_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      event_cnt_q  <= event_cnt_d;
      neck_pulse_q <= (state_d == ST_PULSE);
    end
  end

  assign neck_pulse = neck_pulse_q;
  assign busy       = (state_q == ST_PULSE) || (state_q == ST_HOLDOFF);
  assign event_cnt  = event_cnt_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_neck_pulse_ctrl.sv
// Bench for neck_pulse_ctrl: two configurations driven by shared stimulus,
// each checked every cycle against a timer-based behavioural model.
module tb_neck_pulse_ctrl;

  logic clk = 1'b0;
  logic rst, en, nk, ab;

  logic        a_pulse, a_busy, a_armed;
  logic [15:0] a_cnt;
  logic [1:0]  a_st;
  logic        b_pulse, b_busy, b_armed;
  logic [1:0]  b_cnt;
  logic [1:0]  b_st;

  always #5 clk = ~clk;

  neck_pulse_ctrl #(
    .DEBOUNCE_CYC(3), .PULSE_CYC(5), .HOLDOFF_CYC(8), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .en_ctrl(en), .necking_in(nk), .abort_in(ab),
    .neck_pulse(a_pulse), .busy(a_busy), .armed(a_armed),
    .event_cnt(a_cnt), .ctrl_state(a_st)
  );

  neck_pulse_ctrl #(
    .DEBOUNCE_CYC(1), .PULSE_CYC(5), .HOLDOFF_CYC(0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en_ctrl(en), .necking_in(nk), .abort_in(ab),
    .neck_pulse(b_pulse), .busy(b_busy), .armed(b_armed),
    .event_cnt(b_cnt), .ctrl_state(b_st)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining pulse / hold-off time, run of high samples,
  // arm flag and event count per configuration.
  int deb_c[2]  = '{3, 1};
  int pul_c[2]  = '{5, 5};
  int hold_c[2] = '{8, 0};
  int max_c[2]  = '{65535, 3};
  int m_pulse[2], m_hold[2], m_run[2], m_armed[2], m_cnt[2];

  task automatic model_edge(input int d, input logic r, input logic e,
                            input logic n, input logic a);
    if (r) begin
      m_pulse[d] = 0; m_hold[d] = 0; m_run[d] = 0; m_armed[d] = 0; m_cnt[d] = 0;
    end else if (m_pulse[d] > 0) begin
      if (a || m_pulse[d] == 1) begin
        m_pulse[d] = 0;
        m_hold[d]  = hold_c[d];
      end else m_pulse[d]--;
    end else if (m_hold[d] > 0) begin
      m_hold[d]--;
    end else if (!n) begin
      m_armed[d] = 1;
      m_run[d]   = 0;
    end else if (!e) begin
      m_run[d] = 0;
    end else if (m_run[d] > 0 || m_armed[d] != 0) begin
      m_run[d]++;
      if (m_run[d] == deb_c[d]) begin
        m_run[d]   = 0;
        m_armed[d] = 0;
        m_pulse[d] = pul_c[d];
        if (m_cnt[d] < max_c[d]) m_cnt[d]++;
      end
    end
  endtask

  function automatic int exp_state(input int d);
    if (m_pulse[d] > 0) return 2;
    if (m_hold[d] > 0)  return 3;
    if (m_run[d] > 0)   return 1;
    return 0;
  endfunction

  int   a_rises, a_highs, a_busy_n, b_rises;
  logic a_prev = 1'b0, b_prev = 1'b0;

  task automatic clr_stats();
    a_rises = 0; a_highs = 0; a_busy_n = 0; b_rises = 0;
  endtask

  task automatic step(input logic r, input logic e, input logic n, input logic a);
    rst = r; en = e; nk = n; ab = a;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, r, e, n, a);
    #1;
    chk("A.neck_pulse", 32'(a_pulse), 32'(m_pulse[0] > 0));
    chk("A.busy",       32'(a_busy),  32'(m_pulse[0] > 0 || m_hold[0] > 0));
    chk("A.armed",      32'(a_armed), 32'(m_armed[0]));
    chk("A.event_cnt",  32'(a_cnt),   32'(m_cnt[0]));
    chk("A.ctrl_state", 32'(a_st),    32'(exp_state(0)));
    chk("B.neck_pulse", 32'(b_pulse), 32'(m_pulse[1] > 0));
    chk("B.busy",       32'(b_busy),  32'(m_pulse[1] > 0 || m_hold[1] > 0));
    chk("B.armed",      32'(b_armed), 32'(m_armed[1]));
    chk("B.event_cnt",  32'(b_cnt),   32'(m_cnt[1]));
    chk("B.ctrl_state", 32'(b_st),    32'(exp_state(1)));
    if (a_pulse && !a_prev) a_rises++;
    if (a_pulse) a_highs++;
    if (a_busy) a_busy_n++;
    if (b_pulse && !b_prev) b_rises++;
    a_prev = a_pulse;
    b_prev = b_pulse;
  endtask

  task automatic do_reset(input logic n);
    step(1, 1, n, 0);
    step(1, 1, n, 0);
  endtask

  int lat;
  logic rn, re, ra, rr;

  initial begin
    rst = 1'b1; en = 1'b1; nk = 1'b1; ab = 1'b0;
    for (int d = 0; d < 2; d++) model_edge(d, 1'b1, 1'b1, 1'b1, 1'b0);

    // Stuck-high input out of reset must never fire.
    do_reset(1);
    chk("rst.pulse", 32'(a_pulse), 0);
    chk("rst.busy",  32'(a_busy),  0);
    chk("rst.armed", 32'(a_armed), 0);
    chk("rst.cnt",   32'(a_cnt),   0);
    chk("rst.state", 32'(a_st),    0);
    clr_stats();
    for (int i = 0; i < 50; i++) step(0, 1, 1, 0);
    chk("s1.no_pulse", 32'(a_rises), 0);
    chk("s1.cnt",      32'(a_cnt),   0);
    step(0, 1, 0, 0);
    lat = 0;
    while (lat < 10) begin
      step(0, 1, 1, 0);
      lat++;
      if (a_pulse) break;
    end
    chk("s1.latency", 32'(lat), 3);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);

    // Short burst aborts qualification; second burst qualifies.
    do_reset(0);
    clr_stats();
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("s2.before_3rd", 32'(a_pulse), 0);
    step(0, 1, 1, 0);
    chk("s2.at_3rd", 32'(a_pulse), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("s2.rises", 32'(a_rises), 1);
    chk("s2.width", 32'(a_highs), 5);
    chk("s2.cnt",   32'(a_cnt),   1);

    // Held high through pulse and hold-off: no re-fire until seen low.
    do_reset(0);
    step(0, 1, 0, 0);
    clr_stats();
    for (int i = 0; i < 26; i++) step(0, 1, 1, 0);
    chk("s3.busy_cycles", 32'(a_busy_n), 13);
    chk("s3.rises",       32'(a_rises),  1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    chk("s3.second_pulse", 32'(a_pulse), 1);
    chk("s3.cnt",          32'(a_cnt),   2);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0);

    // Abort on the second pulse cycle.
    do_reset(0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    clr_stats();
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("s4.cut", 32'(a_pulse), 0);
    chk("s4.busy_after_abort", 32'(a_busy), 1);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    chk("s4.highs", 32'(a_highs), 2);
    chk("s4.busy_cycles", 32'(a_busy_n), 10);

    // Reset mid-pulse.
    do_reset(0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("s5.pulse", 32'(a_pulse), 0);
    chk("s5.state", 32'(a_st),    0);
    chk("s5.cnt",   32'(a_cnt),   0);
    clr_stats();
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0);
    chk("s5.no_refire", 32'(a_rises), 0);

    // Single-sample debounce, no hold-off, narrow saturating counter.
    do_reset(0);
    clr_stats();
    for (int ev = 0; ev < 5; ev++) begin
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      chk("s6.latency", 32'(b_pulse), 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    end
    chk("s6.rises", 32'(b_rises), 5);
    chk("s6.sat",   32'(b_cnt),   3);

    // Random traffic, checked every cycle against the model.
    do_reset(0);
    rn = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rn = ~rn;
      re = ($urandom_range(0, 15) != 0);
      ra = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rr, re, rn, ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neck_pulse_ctrl.md
Name: neck_pulse_ctrl

Overview:
- Downstream of the necking-judge stage; consumes its raw 1-bit necking_signal in the 100 MHz clk_100m domain.
- Debounces necking_signal and emits one fixed-width, registered neck_pulse per qualified event to the welding power-stage interface.
- After each pulse, enforces a hold-off window and requires necking_in to return low before re-arming.
- Maintains a saturating event counter for diagnostics.

Parameters:
- DEBOUNCE_CYC, 4, consecutive high samples of necking_in needed to qualify an event; legal range 1 or more.
- PULSE_CYC, 500, neck_pulse high width in clk cycles (5 us at 100 MHz); legal range 1 or more.
- HOLDOFF_CYC, 20000, refractory cycles after the pulse (200 us); 0 skips HOLDOFF.
- CNT_W, 16, event_cnt width.

Ports:
- clk  in  1  system clock (clk_100m)
- rst  in  1  synchronous reset, active-high
- en_ctrl  in  1  block enable
- necking_in  in  1  raw necking flag from the judge stage
- abort_in  in  1  arc re-short detected; truncates an active pulse
- neck_pulse  out  1  qualified necking pulse, registered
- busy  out  1  high in PULSE or HOLDOFF
- armed  out  1  necking_in has been seen low since the last event
- event_cnt  out  CNT_W  number of qualified events, saturating
- ctrl_state  out  2  encoded FSM state for debug

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all flops are reset on a clk edge while rst=1.
- Reset values:
  - neck_pulse=0, busy=0, armed=0, event_cnt=0.
  - State IDLE (ctrl_state=0), internal counters 0.
- States and encoding: IDLE=0, QUALIFY=1, PULSE=2, HOLDOFF=3.
- armed:
  - Set on any edge where necking_in=0 and state is IDLE or QUALIFY.
  - Cleared on entry to PULSE.
  - rst leaves armed=0, so a necking_in stuck high out of reset never fires.
- IDLE:
  - If en_ctrl=1, armed=1 and necking_in=1: go to QUALIFY with qual_cnt=1.
  - If DEBOUNCE_CYC=1, go straight to PULSE instead.
- QUALIFY:
  - necking_in=1: qual_cnt increments. On the edge where the DEBOUNCE_CYC-th consecutive high sample is taken, go to PULSE.
  - necking_in=0 or en_ctrl=0: return to IDLE, qual_cnt=0.
- PULSE:
  - neck_pulse=1 for exactly PULSE_CYC cycles, then go to HOLDOFF (or to IDLE if HOLDOFF_CYC=0).
  - event_cnt increments by 1 on PULSE entry and saturates at all-ones.
  - abort_in=1: neck_pulse drops on the next edge and the FSM goes to HOLDOFF. abort_in has no effect in other states.
- HOLDOFF:
  - necking_in is ignored for exactly HOLDOFF_CYC cycles, then go to IDLE.
  - Re-triggering additionally needs armed, i.e. necking_in must be seen low at least once.
- Latency: necking_in first sampled high at edge k and held high → neck_pulse=1 after edge k+DEBOUNCE_CYC-1.
- en_ctrl=0 during PULSE or HOLDOFF does not truncate; the sequence completes, then the FSM parks in IDLE.
- rst mid-PULSE: neck_pulse=0 on the same edge, no further count.
- Counter widths are $clog2 of each parameter+1; no wrap is possible.

Decomposition:
- Package neck_pkg:
  - State enum (2-bit) and state codes.
  - CLK_FREQ_HZ=100_000_000.
  - Default timing constants (DEBOUNCE_CYC, PULSE_CYC, HOLDOFF_CYC).
- One sub-module, neck_debounce:
  - Owns qual_cnt and armed.
  - Outputs a one-cycle qualified strobe to the main FSM/timer.

Test Plan (DEBOUNCE_CYC=3, PULSE_CYC=5, HOLDOFF_CYC=8 unless noted):
- Reset release, necking_in tied high → neck_pulse stays 0 for 50 cycles and event_cnt=0; drop necking_in for 1 cycle, then raise → pulse 3 edges after the rise.
- necking_in high for 2 cycles, low, high for 3 cycles → exactly one pulse, 5 cycles wide, starting after the 3rd high sample of the second burst; event_cnt=1.
- necking_in held high through the pulse and hold-off → busy high for 13 cycles, no second pulse; then drop low 1 cycle and raise → second pulse, event_cnt=2.
- abort_in=1 on the 2nd pulse cycle → neck_pulse high for 2 cycles total; busy stays high for the following 8 hold-off cycles.
- rst asserted on the 3rd pulse cycle → neck_pulse=0 and ctrl_state=0 on that edge; event_cnt=0.
- DEBOUNCE_CYC=1, HOLDOFF_CYC=0, CNT_W=2, with 5 armed events → pulse after 1 edge each, back-to-back re-arm allowed, event_cnt saturates at 3.
